nco_equiv_monitor: RTL and testbench

Synthesizable runtime lockstep checker for the NCO/DSP datapaths. It compares a reference stream against a device-under-test stream with a parametrised fixed lag, data width and settle window, then reports a sticky fail flag, a per-event pulse, a saturating mismatch count and a first-mismatch snapshot. It sits beside two NCO instances in on-board builds and simulation benches, and complements formal equivalence with checking on live hardware.

---
 rtl/nco_equiv_monitor.sv | 161 ++++++++++++++++
 tb/tb_nco_equiv_monitor.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_equiv_monitor.sv
// Runtime lockstep checker: compares a lag-aligned reference stream with a DUT stream
// and reports a sticky fail, a per-event pulse, a saturating count and a first-mismatch snapshot.
module nco_equiv_monitor #(
  parameter int DW           = 8,
  parameter int LAG          = 0,
  parameter int SETTLE       = 4,
  parameter int CNT_W        = 16,
  parameter int TS_W         = 32,
  parameter bit STOP_ON_FAIL = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_ref_valid,
  input  logic [DW-1:0]    i_ref_data,
  input  logic             i_dut_valid,
  input  logic [DW-1:0]    i_dut_data,
  output logic             o_checking,
  output logic             o_fail,
  output logic             o_mismatch,
  output logic [CNT_W-1:0] o_mismatch_cnt,
  output logic [DW-1:0]    o_first_ref,
  output logic [DW-1:0]    o_first_dut,
  output logic [TS_W-1:0]  o_first_ts
);

  localparam int TOTAL = SETTLE + LAG;
  localparam int SC_W  = (TOTAL < 1) ? 1 : $clog2(TOTAL + 1);
  localparam logic [SC_W-1:0] SC_END = SC_W'(TOTAL);

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_CHECK  = 2'd1,
    ST_FAILED = 2'd2
  } state_t;

  logic          rv;
  logic [DW-1:0] rd;

  generate
    if (LAG == 0) begin : g_no_lag
      assign rv = i_ref_valid;
      assign rd = i_ref_data;
    end else begin : g_lag
      logic [LAG-1:0]         dly_valid_q, dly_valid_d;
      logic [LAG-1:0][DW-1:0] dly_data_q, dly_data_d;

      always_comb begin
        dly_valid_d[0] = i_ref_valid;
        dly_data_d[0]  = i_ref_data;
        for (int i = 1; i < LAG; i++) begin
          dly_valid_d[i] = dly_valid_q[i-1];
          dly_data_d[i]  = dly_data_q[i-1];
        end
      end

      // NOTE: this shift register is reset because stale samples would otherwise be
      // compared right after reset; plain storage arrays need no reset and should not get one.
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          dly_valid_q <= '0;
          dly_data_q  <= '0;
        end else begin
          dly_valid_q <= dly_valid_d;
          dly_data_q  <= dly_data_d;
        end
      end

      assign rv = dly_valid_q[LAG-1];
      assign rd = dly_data_q[LAG-1];
    end
  endgenerate

  state_t            state_q, state_d, cur_state, eff_state;
  logic [SC_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic              fail_q, fail_d;
  logic              mismatch_q, mismatch_d;
  logic              checking_q, checking_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DW-1:0]     first_ref_q, first_ref_d;
  logic [DW-1:0]     first_dut_q, first_dut_d;
  logic [TS_W-1:0]   first_ts_q, first_ts_d;
  logic              mismatch_raw, counted;

  // NOTE: every signal below gets a default first so no path can leave it unassigned
  // and infer a latch; blocking '=' is correct here, only the flops use '<='.
  always_comb begin
    ts_d = ts_q + TS_W'(1);

    // The compare cycle where the settle counter hits its end already behaves as CHECK.
    cur_state = state_q;
    if (state_q == ST_SETTLE && settle_cnt_q == SC_END) cur_state = ST_CHECK;

    settle_cnt_d = settle_cnt_q;
    if (cur_state == ST_SETTLE) settle_cnt_d = settle_cnt_q + SC_W'(1);

    // Clear acts before any same-cycle mismatch, so it re-arms FAILED and wipes results.
    eff_state = cur_state;
    if (i_clear && cur_state == ST_FAILED) eff_state = ST_CHECK;

    fail_d      = i_clear ? 1'b0 : fail_q;
    cnt_d       = i_clear ? '0 : cnt_q;
    first_ref_d = i_clear ? '0 : first_ref_q;
    first_dut_d = i_clear ? '0 : first_dut_q;
    first_ts_d  = i_clear ? '0 : first_ts_q;

    mismatch_raw = (rv != i_dut_valid) || (rv && i_dut_valid && (rd != i_dut_data));
    counted      = mismatch_raw && (eff_state == ST_CHECK);

    state_d    = eff_state;
    mismatch_d = counted;
    checking_d = (cur_state != ST_SETTLE);

    if (counted) begin
      if (cnt_d != '1) cnt_d = cnt_d + CNT_W'(1);
      if (!fail_d) begin
        first_ref_d = rd;
        first_dut_d = i_dut_data;
        first_ts_d  = ts_q;
      end
      fail_d = 1'b1;
      if (STOP_ON_FAIL) state_d = ST_FAILED;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_SETTLE;
      settle_cnt_q <= '0;
      ts_q         <= '0;
      fail_q       <= 1'b0;
      mismatch_q   <= 1'b0;
      checking_q   <= 1'b0;
      cnt_q        <= '0;
      first_ref_q  <= '0;
      first_dut_q  <= '0;
      first_ts_q   <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      ts_q         <= ts_d;
      fail_q       <= fail_d;
      mismatch_q   <= mismatch_d;
      checking_q   <= checking_d;
      cnt_q        <= cnt_d;
      first_ref_q  <= first_ref_d;
      first_dut_q  <= first_dut_d;
      first_ts_q   <= first_ts_d;
    end
  end

  assign o_checking     = checking_q;
  assign o_fail         = fail_q;
  assign o_mismatch     = mismatch_q;
  assign o_mismatch_cnt = cnt_q;
  assign o_first_ref    = first_ref_q;
  assign o_first_dut    = first_dut_q;
  assign o_first_ts     = first_ts_q;

endmodule

// File: tb/tb_nco_equiv_monitor.sv
// Directed bench for nco_equiv_monitor: three instances cover default, lagged and
// non-stopping/narrow-counter configurations.
module tb_nco_equiv_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, clear;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  // Instance A: defaults (LAG=0, SETTLE=4, STOP_ON_FAIL=1)
  logic        a_ref_v, a_dut_v;
  logic [7:0]  a_ref_d, a_dut_d;
  logic        a_checking, a_fail, a_mismatch;
  logic [15:0] a_cnt;
  logic [7:0]  a_first_ref, a_first_dut;
  logic [31:0] a_first_ts;

  // Instance B: LAG=3
  logic        b_ref_v, b_dut_v;
  logic [7:0]  b_ref_d, b_dut_d;
  logic        b_checking, b_fail, b_mismatch;
  logic [15:0] b_cnt;
  logic [7:0]  b_first_ref, b_first_dut;
  logic [31:0] b_first_ts;

  // Instance C: CNT_W=4, STOP_ON_FAIL=0
  logic        c_ref_v, c_dut_v;
  logic [7:0]  c_ref_d, c_dut_d;
  logic        c_checking, c_fail, c_mismatch;
  logic [3:0]  c_cnt;
  logic [7:0]  c_first_ref, c_first_dut;
  logic [31:0] c_first_ts;

  nco_equiv_monitor u_a (
    .i_clk(clk), .i_reset(reset), .i_clear(clear),
    .i_ref_valid(a_ref_v), .i_ref_data(a_ref_d),
    .i_dut_valid(a_dut_v), .i_dut_data(a_dut_d),
    .o_checking(a_checking), .o_fail(a_fail), .o_mismatch(a_mismatch),
    .o_mismatch_cnt(a_cnt), .o_first_ref(a_first_ref),
    .o_first_dut(a_first_dut), .o_first_ts(a_first_ts)
  );

  nco_equiv_monitor #(.LAG(3)) u_b (
    .i_clk(clk), .i_reset(reset), .i_clear(clear),
    .i_ref_valid(b_ref_v), .i_ref_data(b_ref_d),
    .i_dut_valid(b_dut_v), .i_dut_data(b_dut_d),
    .o_checking(b_checking), .o_fail(b_fail), .o_mismatch(b_mismatch),
    .o_mismatch_cnt(b_cnt), .o_first_ref(b_first_ref),
    .o_first_dut(b_first_dut), .o_first_ts(b_first_ts)
  );

  nco_equiv_monitor #(.CNT_W(4), .STOP_ON_FAIL(1'b0)) u_c (
    .i_clk(clk), .i_reset(reset), .i_clear(clear),
    .i_ref_valid(c_ref_v), .i_ref_data(c_ref_d),
    .i_dut_valid(c_dut_v), .i_dut_data(c_dut_d),
    .o_checking(c_checking), .o_fail(c_fail), .o_mismatch(c_mismatch),
    .o_mismatch_cnt(c_cnt), .o_first_ref(c_first_ref),
    .o_first_dut(c_first_dut), .o_first_ts(c_first_ts)
  );

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    clear = 1'b0;
    a_ref_v = 0; a_dut_v = 0; a_ref_d = 0; a_dut_d = 0;
    b_ref_v = 0; b_dut_v = 0; b_ref_d = 0; b_dut_d = 0;
    c_ref_v = 0; c_dut_v = 0; c_ref_d = 0; c_dut_d = 0;
  endtask

  // Leaves the bench in cycle 0 (first cycle after reset) with idle inputs.
  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_ref_v = 1; a_dut_v = 0; a_ref_d = 8'h5A; a_dut_d = 8'hA5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_inputs();
    cyc = 0;
    checks++;
    if ({a_checking, a_fail, a_mismatch, a_cnt, a_first_ref, a_first_dut, a_first_ts} !== '0) begin
      errors++;
      $display("FAIL reset_a: outputs %0h, required 0",
               {a_checking, a_fail, a_mismatch, a_cnt, a_first_ref, a_first_dut, a_first_ts});
    end
    checks++;
    if ({b_checking, b_fail, b_mismatch, b_cnt, c_checking, c_fail, c_mismatch, c_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_bc: outputs %0h, required 0",
               {b_checking, b_fail, b_mismatch, b_cnt, c_checking, c_fail, c_mismatch, c_cnt});
    end
  endtask

  task automatic test_identical();
    logic exp_chk;
    do_reset();
    for (int t = 0; t < 300; t++) begin
      a_ref_v = 1; a_dut_v = 1;
      a_ref_d = t[7:0]; a_dut_d = t[7:0];
      step();
      exp_chk = (cyc >= 5);
      checks++;
      if (a_checking !== exp_chk) begin
        errors++;
        $display("FAIL identical_checking cyc %0d: got %b, required %b", cyc, a_checking, exp_chk);
      end
    end
    checks++;
    if (a_fail !== 1'b0 || a_cnt !== 16'd0) begin
      errors++;
      $display("FAIL identical_clean: fail %b cnt %0d, required 0 0", a_fail, a_cnt);
    end
  endtask

  task automatic test_settle_and_valid_only();
    do_reset();
    for (int t = 0; t < 4; t++) begin
      a_ref_v = 1; a_dut_v = 1; a_ref_d = 8'h11; a_dut_d = 8'h22;
      step();
    end
    checks++;
    if ({a_fail, a_mismatch, a_cnt} !== '0 || a_checking !== 1'b0) begin
      errors++;
      $display("FAIL settle_masking: fail %b mm %b cnt %0d chk %b, required 0 0 0 0",
               a_fail, a_mismatch, a_cnt, a_checking);
    end
    for (int t = 4; t < 10; t++) begin
      a_ref_v = 0; a_dut_v = 0; a_ref_d = 8'h33; a_dut_d = 8'h44;
      step();
    end
    checks++;
    if (a_cnt !== 16'd0 || a_checking !== 1'b1) begin
      errors++;
      $display("FAIL both_invalid: cnt %0d chk %b, required 0 1", a_cnt, a_checking);
    end
    a_ref_v = 1; a_dut_v = 0; a_ref_d = 8'h12; a_dut_d = 8'h34;
    step();
    a_ref_v = 0;
    checks++;
    if ({a_mismatch, a_fail, a_cnt, a_first_ref, a_first_dut, a_first_ts}
        !== {1'b1, 1'b1, 16'd1, 8'h12, 8'h34, 32'd10}) begin
      errors++;
      $display("FAIL valid_only: mm %b fail %b cnt %0d ref %h dut %h ts %0d, required 1 1 1 12 34 10",
               a_mismatch, a_fail, a_cnt, a_first_ref, a_first_dut, a_first_ts);
    end
  endtask

  task automatic test_single_corrupt();
    do_reset();
    for (int t = 0; t < 20; t++) begin
      a_ref_v = 1; a_dut_v = 1; a_ref_d = t[7:0]; a_dut_d = t[7:0];
      step();
    end
    a_ref_d = 8'h40; a_dut_d = 8'h41;
    step();
    checks++;
    if ({a_mismatch, a_fail, a_cnt, a_first_ref, a_first_dut, a_first_ts}
        !== {1'b1, 1'b1, 16'd1, 8'h40, 8'h41, 32'd20}) begin
      errors++;
      $display("FAIL single_corrupt: mm %b fail %b cnt %0d ref %h dut %h ts %0d, required 1 1 1 40 41 20",
               a_mismatch, a_fail, a_cnt, a_first_ref, a_first_dut, a_first_ts);
    end
    for (int t = 0; t < 5; t++) begin
      a_ref_d = 8'h00; a_dut_d = 8'hFF;
      step();
      checks++;
      if (a_mismatch !== 1'b0 || a_cnt !== 16'd1 || a_first_ref !== 8'h40 || a_checking !== 1'b1) begin
        errors++;
        $display("FAIL failed_hold: mm %b cnt %0d ref %h chk %b, required 0 1 40 1",
                 a_mismatch, a_cnt, a_first_ref, a_checking);
      end
    end
  endtask

  // Runs from the FAILED state left by test_single_corrupt.
  task automatic test_clear_and_reset();
    int k;
    k = cyc;
    clear = 1; a_ref_v = 1; a_dut_v = 1; a_ref_d = 8'h55; a_dut_d = 8'hAA;
    step();
    clear = 0;
    checks++;
    if ({a_mismatch, a_fail, a_cnt, a_first_ref, a_first_dut} !== {1'b1, 1'b1, 16'd1, 8'h55, 8'hAA}
        || a_first_ts !== 32'(k)) begin
      errors++;
      $display("FAIL clear_collision: mm %b fail %b cnt %0d ref %h dut %h ts %0d, required 1 1 1 55 aa %0d",
               a_mismatch, a_fail, a_cnt, a_first_ref, a_first_dut, a_first_ts, k);
    end
    clear = 1; a_ref_d = 8'h07; a_dut_d = 8'h07;
    step();
    clear = 0;
    checks++;
    if ({a_mismatch, a_fail, a_cnt, a_first_ref, a_first_dut, a_first_ts} !== '0 || a_checking !== 1'b1) begin
      errors++;
      $display("FAIL clear_only: mm %b fail %b cnt %0d ref %h ts %0d chk %b, required 0 0 0 0 0 1",
               a_mismatch, a_fail, a_cnt, a_first_ref, a_first_ts, a_checking);
    end
    k = cyc;
    a_ref_d = 8'h01; a_dut_d = 8'h02;
    step();
    checks++;
    if ({a_mismatch, a_cnt, a_first_ref, a_first_dut} !== {1'b1, 16'd1, 8'h01, 8'h02}
        || a_first_ts !== 32'(k)) begin
      errors++;
      $display("FAIL rearm_after_clear: mm %b cnt %0d ref %h dut %h ts %0d, required 1 1 01 02 %0d",
               a_mismatch, a_cnt, a_first_ref, a_first_dut, a_first_ts, k);
    end
    reset = 1; a_ref_d = 8'h0F; a_dut_d = 8'hF0;
    @(posedge clk); #1;
    reset = 0;
    cyc = 0;
    checks++;
    if ({a_checking, a_fail, a_mismatch, a_cnt, a_first_ref, a_first_dut, a_first_ts} !== '0) begin
      errors++;
      $display("FAIL reset_mid_failed: outputs %0h, required 0",
               {a_checking, a_fail, a_mismatch, a_cnt, a_first_ref, a_first_dut, a_first_ts});
    end
    for (int t = 0; t < 4; t++) step();
    checks++;
    if (a_cnt !== 16'd0 || a_checking !== 1'b0) begin
      errors++;
      $display("FAIL reset_back_to_settle: cnt %0d chk %b, required 0 0", a_cnt, a_checking);
    end
    a_ref_d = 8'h00; a_dut_d = 8'h00;
    step();
    checks++;
    if (a_checking !== 1'b1 || a_cnt !== 16'd0) begin
      errors++;
      $display("FAIL resettle_checking: chk %b cnt %0d, required 1 0", a_checking, a_cnt);
    end
  endtask

  task automatic test_lag_alignment();
    logic exp_chk;
    do_reset();
    for (int t = 0; t < 40; t++) begin
      b_ref_v = 1; b_ref_d = 8'(t + 16);
      b_dut_v = (t >= 3);
      b_dut_d = (t >= 3) ? 8'(t - 3 + 16) : 8'h00;
      step();
      exp_chk = (cyc >= 8);
      checks++;
      if (b_checking !== exp_chk) begin
        errors++;
        $display("FAIL lag_checking cyc %0d: got %b, required %b", cyc, b_checking, exp_chk);
      end
    end
    checks++;
    if (b_fail !== 1'b0 || b_cnt !== 16'd0) begin
      errors++;
      $display("FAIL lag_aligned: fail %b cnt %0d, required 0 0", b_fail, b_cnt);
    end
    b_ref_d = 8'(40 + 16); b_dut_d = 8'(40 - 2 + 16);
    step();
    checks++;
    if ({b_mismatch, b_fail, b_cnt, b_first_ref, b_first_dut, b_first_ts}
        !== {1'b1, 1'b1, 16'd1, 8'h35, 8'h36, 32'd40}) begin
      errors++;
      $display("FAIL lag_misaligned: mm %b fail %b cnt %0d ref %h dut %h ts %0d, required 1 1 1 35 36 40",
               b_mismatch, b_fail, b_cnt, b_first_ref, b_first_dut, b_first_ts);
    end
  endtask

  task automatic test_continuous();
    logic [3:0] exp_cnt;
    do_reset();
    for (int t = 0; t < 4; t++) begin
      c_ref_v = 1; c_dut_v = 1; c_ref_d = t[7:0]; c_dut_d = t[7:0];
      step();
    end
    for (int t = 4; t < 24; t++) begin
      c_ref_d = t[7:0]; c_dut_d = ~c_ref_d;
      step();
      exp_cnt = (t - 3 > 15) ? 4'd15 : 4'(t - 3);
      checks++;
      if (c_cnt !== exp_cnt || c_mismatch !== 1'b1) begin
        errors++;
        $display("FAIL continuous_cnt cyc %0d: cnt %0d mm %b, required %0d 1", cyc, c_cnt, c_mismatch, exp_cnt);
      end
    end
    checks++;
    if ({c_fail, c_first_ref, c_first_dut, c_first_ts} !== {1'b1, 8'h04, 8'hFB, 32'd4}) begin
      errors++;
      $display("FAIL continuous_capture: fail %b ref %h dut %h ts %0d, required 1 04 fb 4",
               c_fail, c_first_ref, c_first_dut, c_first_ts);
    end
    c_ref_d = 8'h99; c_dut_d = 8'h99;
    step();
    checks++;
    if (c_mismatch !== 1'b0 || c_cnt !== 4'd15 || c_checking !== 1'b1) begin
      errors++;
      $display("FAIL continuous_hold: mm %b cnt %0d chk %b, required 0 15 1", c_mismatch, c_cnt, c_checking);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    reset = 1'b0;
    test_reset();
    test_identical();
    test_settle_and_valid_only();
    test_single_corrupt();
    test_clear_and_reset();
    test_lag_alignment();
    test_continuous();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
